// File: rtl/psum_ctrl.sv
// psum_ctrl: sequencing controller for a partial-sum buffer fed by a PE array.
// A job zero-fills the buffer once (INIT). For each output row it then
// accumulates cfg_ch_groups passes of cfg_row_len beats (ACC), waits for the
// adder pipeline to settle (FLUSH), and reads the sums out while writing zeros
// back (DRAIN). A job ends with a one-cycle done pulse (FIN).
// Optional feature: define PSUM_CTRL_PERF_EN to add the perf_cycles and
// perf_stalls counters.
module psum_ctrl #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_row_len,
    input  logic [CNT_W-1:0] cfg_ch_groups,
    input  logic [CNT_W-1:0] cfg_rows,
    input  logic             pe_valid,
    output logic             pe_ready,
    output logic             p_init,
    output logic             p_valid_data,
    output logic             p_write_zero,
    output logic [LEN_W-1:0] col_idx,
    output logic [CNT_W-1:0] ch_idx,
    output logic [CNT_W-1:0] row_idx,
`ifdef PSUM_CTRL_PERF_EN
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls,
`endif
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACC,
        S_FLUSH,
        S_DRAIN,
        S_FIN
    } state_t;

    // The adder pipeline has 3 stages, so the last write retires 3 cycles
    // after the final accepted beat.
    localparam logic [1:0] FLUSH_LAST = 2'd2;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [1:0]         fl_q, fl_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   grp_q, grp_d;
    logic [CNT_W-1:0]   rows_q, rows_d;
    logic               err_q, err_d;

    logic col_last;
    logic ch_last;
    logic row_last;
    logic cfg_zero;
    logic accept;

    assign col_last = (col_q == len_q - LEN_W'(1));
    assign ch_last  = (ch_q == grp_q - CNT_W'(1));
    assign row_last = (row_q == rows_q - CNT_W'(1));
    assign cfg_zero = (cfg_row_len == '0) || (cfg_ch_groups == '0) || (cfg_rows == '0);
    assign accept   = (state_q == S_IDLE) && start;

    // State and counter registers; the latched job configuration lives here too.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            ch_q    <= '0;
            row_q   <= '0;
            fl_q    <= '0;
            len_q   <= '0;
            grp_q   <= '0;
            rows_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            fl_q    <= fl_d;
            len_q   <= len_d;
            grp_q   <= grp_d;
            rows_q  <= rows_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter sequencing for the job.
    // NOTE: every signal gets a hold default before the case so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ch_d    = ch_q;
        row_d   = row_q;
        fl_d    = fl_q;
        len_d   = len_q;
        grp_d   = grp_q;
        rows_d  = rows_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = cfg_row_len;
                    grp_d   = cfg_ch_groups;
                    rows_d  = cfg_rows;
                    col_d   = '0;
                    ch_d    = '0;
                    row_d   = '0;
                    err_d   = cfg_zero;
                    state_d = cfg_zero ? S_FIN : S_INIT;
                end
            end
            S_INIT: begin
                if (col_last) begin
                    col_d   = '0;
                    state_d = S_ACC;
                end else begin
                    col_d = col_q + LEN_W'(1);
                end
            end
            S_ACC: begin
                // pe_ready is always high here, so pe_valid alone marks a beat.
                if (pe_valid) begin
                    if (col_last) begin
                        col_d = '0;
                        if (ch_last) begin
                            fl_d    = '0;
                            state_d = S_FLUSH;
                        end else begin
                            ch_d = ch_q + CNT_W'(1);
                        end
                    end else begin
                        col_d = col_q + LEN_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (fl_q == FLUSH_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    fl_d = fl_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (col_last) begin
                    col_d = '0;
                    if (row_last) begin
                        state_d = S_FIN;
                    end else begin
                        // DRAIN leaves the buffer zero-filled, so the next row
                        // starts accumulating without another INIT.
                        row_d   = row_q + CNT_W'(1);
                        ch_d    = '0;
                        state_d = S_ACC;
                    end
                end else begin
                    col_d = col_q + LEN_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state; pe_valid reaches only p_valid_data.
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign pe_ready     = (state_q == S_ACC);
    assign p_init       = (state_q == S_INIT);
    assign p_valid_data = (state_q == S_ACC) && pe_valid;
    assign p_write_zero = (state_q == S_DRAIN);
    assign col_idx      = col_q;
    assign ch_idx       = ch_q;
    assign row_idx      = row_q;
    assign cfg_err      = err_q;

`ifdef PSUM_CTRL_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] stall_q;

    // Saturating busy-cycle and ACC-stall counters, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (accept) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (busy && (cyc_q != '1)) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if ((state_q == S_ACC) && !pe_valid && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stalls = stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: doc/psum_ctrl.md
PSUM_CTRL -- requirements
Module: psum_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of row-length and column counters.
REQ-002 SHALL have parameter CNT_W, default 8: width of channel-group and row counters.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  job request pulse, sampled only in IDLE.
REQ-006 SHALL have port cfg_row_len  input  LEN_W  partial sums per output row, must not exceed the buffer depth.
REQ-007 SHALL have port cfg_ch_groups  input  CNT_W  accumulation passes per row.
REQ-008 SHALL have port cfg_rows  input  CNT_W  output rows per job.
REQ-009 SHALL have port pe_valid  input  1  PE array presents one valid beat this cycle.
REQ-010 SHALL have port pe_ready  output  1  controller accepts a PE beat this cycle.
REQ-011 SHALL have ports p_init, p_valid_data, p_write_zero  output  1 each  partial-sum buffer controls.
REQ-012 SHALL have ports col_idx (LEN_W), ch_idx (CNT_W), row_idx (CNT_W)  output  current position.
REQ-013 SHALL have ports busy, done, cfg_err  output  1 each  status.

Function
REQ-014 SHALL latch cfg_* on an accepted start; later cfg changes do not affect the running job.
REQ-015 SHALL implement states IDLE, INIT, ACC, FLUSH, DRAIN, FIN.
REQ-016 IDLE: on start with all cfg fields nonzero, go to INIT; if any field is zero, go to FIN with cfg_err=1.
REQ-017 INIT: assert p_init for exactly cfg_row_len cycles (col_idx 0..len-1), then go to ACC with ch_idx=0.
REQ-018 ACC: pe_ready=1; p_valid_data = pe_valid; col_idx advances only on an accepted beat (pe_valid & pe_ready).
REQ-019 ACC: after beat len-1 of a pass, if ch_idx < groups-1, increment ch_idx, clear col_idx, and stay in ACC with no idle cycle; otherwise go to FLUSH.
REQ-020 FLUSH: hold all buffer controls low for exactly 3 cycles so the 3-stage adder pipeline retires its last write, then go to DRAIN.
REQ-021 DRAIN: assert p_write_zero for exactly cfg_row_len cycles, reading final sums out and refilling zeros.
REQ-022 After DRAIN, if row_idx < rows-1, increment row_idx, clear ch_idx and col_idx, and go to ACC, because the buffer is already zero-filled; otherwise go to FIN.
REQ-023 FIN: done=1 for exactly one cycle, then IDLE.
REQ-024 p_init, p_valid_data, and p_write_zero SHALL be mutually exclusive in every cycle.
REQ-025 pe_ready=0 outside ACC; PE beats outside ACC are ignored.
REQ-026 busy=1 in every state except IDLE; start while busy is ignored.
REQ-027 cfg_err SHALL hold until the next accepted start.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from pe_valid except to p_valid_data.
REQ-029 A job of N rows SHALL take len + rows*(groups*len + stall cycles + 3 + len) + 1 cycles from the start cycle to the done pulse.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state IDLE and set every output and counter to 0, including mid-job.
REQ-031 The first start after deassertion SHALL be honoured on the first rising edge.

Configuration
REQ-032 With PSUM_CTRL_PERF_EN defined, SHALL add outputs perf_cycles[31:0], counting busy cycles, and perf_stalls[31:0], counting ACC cycles with pe_valid=0.
REQ-033 With PSUM_CTRL_PERF_EN defined, both counters SHALL clear on accepted start, saturate at all-ones, and hold after done.
REQ-034 Without PSUM_CTRL_PERF_EN, those ports and counters SHALL be absent and all other behaviour is identical.

Verification
REQ-035 len=4, groups=2, rows=1, pe_valid constant 1: 4 p_init cycles, then 8 p_valid_data cycles, 3 idle cycles, 4 p_write_zero cycles, and done at cycle 20 after start.
REQ-036 Same config with pe_valid low on every other ACC cycle: col_idx advances only on valid beats, 8 p_valid_data pulses, and perf_stalls=7 when PSUM_CTRL_PERF_EN is defined.
REQ-037 len=3, groups=1, rows=2: second row enters ACC directly after DRAIN with no p_init, and row_idx goes 0 to 1.
REQ-038 cfg_ch_groups=0: done and cfg_err rise one cycle after start, and no buffer control is ever asserted.
REQ-039 rst_n pulsed low during DRAIN: all outputs are 0 at once, busy=0, and a new start runs a full job correctly.
REQ-040 start pulsed during ACC: ignored; latched cfg and counters are unaffected.
